// File: rtl/bitstream_pkg.sv
// Shared definitions for the bitstream scheduler.
//   sched_state_t : scheduler FSM states
//   fifo_entry_t  : one buffered symbol (mode tag + 2-bit symbol)
//   LFSR_TAP_*    : taps of the 32-bit symbol LFSR
//   DEFAULT_SEED  : LFSR value after reset unless overridden
//   lfsr_next()   : one LFSR step
package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic       mode;  // 0: 1-bit symbol, 1: 2-bit symbol
    logic [1:0] sym;
  } fifo_entry_t;

  localparam int unsigned LFSR_TAP_A   = 25;
  localparam int unsigned LFSR_TAP_B   = 15;
  localparam int unsigned LFSR_TAP_C   = 5;
  localparam logic [31:0] DEFAULT_SEED = 32'd165;

  // Shift right, feedback enters at bit 31. The inverted tap keeps the
  // all-zero state from locking up.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic fb;
    fb = s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ ~s[LFSR_TAP_C];
    return {fb, s[31:1]};
  endfunction

endpackage

// File: rtl/lfsr32_step.sv
// 32-bit LFSR register with load and single-step controls.
//   clk, rst_n : clock, asynchronous active-low reset (loads SEED)
//   step       : advance one position this cycle
//   load       : replace the state with load_val (wins over step)
//   load_val   : value used by load
//   state      : current LFSR contents
module lfsr32_step
  import bitstream_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] state
);

  logic [31:0] state_q;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= load_val;
    end else if (step) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/bitstream_sched.sv
// Paced random-symbol generator. Symbols derived from an LFSR are buffered
// in a small FIFO and released one per SAMPLES_PER_SYM clocks.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, stop  : single-cycle run control (stop wins when both are high)
//   hold         : freezes the LFSR and FIFO filling
//   mode_req     : 0 = 1-bit symbols, 1 = 2-bit symbols (tagged per entry)
//   seed_load    : load seed_in into the LFSR (IDLE only)
//   sym_data     : current symbol, mode_active its tag, sym_valid new-symbol pulse
//   busy         : state is not IDLE
//   underrun     : sticky, pacing strobe in RUN found the FIFO empty
//   underrun_cnt : saturating underrun count, present only when the macro
//                  BITSTREAM_SCHED_UNDERRUN_CNT_EN is defined
module bitstream_sched
  import bitstream_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_SYM = 32,
  parameter logic [31:0] SEED_DEFAULT    = DEFAULT_SEED,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        hold,
  input  logic        mode_req,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  output logic [1:0]  sym_data,
  output logic        sym_valid,
  output logic        mode_active,
  output logic        busy,
  output logic        underrun
`ifdef BITSTREAM_SCHED_UNDERRUN_CNT_EN
  ,output logic [15:0] underrun_cnt
`endif
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = $clog2(SAMPLES_PER_SYM);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] PACE_LAST = CW'(SAMPLES_PER_SYM - 1);
  localparam logic [CW-1:0] PACE_ONE  = CW'(1);

  sched_state_t  state_q, state_d;
  fifo_entry_t   fifo_q [FIFO_DEPTH];
  fifo_entry_t   push_entry, head_entry;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;
  logic [CW-1:0] pace_q;
  logic [1:0]    sym_data_q;
  logic          sym_valid_q, mode_active_q, underrun_q;
  logic [31:0]   lfsr_state;

  logic start_acc, prime_stop, fifo_full, fifo_empty;
  logic push, pacing, strobe, pop, underrun_hit;

  assign start_acc    = (state_q == IDLE) && start && !stop;
  assign prime_stop   = (state_q == PRIME) && stop;
  assign fifo_full    = (fill_q == FULL_CNT);
  assign fifo_empty   = (fill_q == '0);
  // A stop in PRIME flushes the FIFO, so nothing is pushed on that edge.
  assign push         = ((state_q == PRIME) || (state_q == RUN)) && !fifo_full
                        && !hold && !prime_stop;
  assign pacing       = (state_q == RUN) || (state_q == DRAIN);
  assign strobe       = pacing && (pace_q == PACE_LAST);
  assign pop          = strobe && !fifo_empty;
  assign underrun_hit = strobe && fifo_empty && (state_q == RUN);

  lfsr32_step #(
    .SEED (SEED_DEFAULT)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (push),
    .load     (seed_load && (state_q == IDLE)),
    .load_val (seed_in),
    .state    (lfsr_state)
  );

  // The pushed symbol comes from the post-step value, whose bits [1:0]
  // are the current state's bits [2:1].
  assign push_entry.mode = mode_req;
  assign push_entry.sym  = mode_req ? lfsr_state[2:1] : {1'b0, lfsr_state[1]};
  assign head_entry      = fifo_q[rd_ptr_q];

  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^{lfsr_state[31:3], lfsr_state[0]};

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + CNT_ONE;
    end else if (pop && !push) begin
      fill_d = fill_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_acc) state_d = PRIME;
      PRIME:   if (stop) state_d = IDLE;
               else if (fill_d == FULL_CNT) state_d = RUN;
      RUN:     if (stop) state_d = DRAIN;
      DRAIN:   if (strobe && (fill_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      pace_q   <= '0;
    end else begin
      state_q <= state_d;
      if (prime_stop) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fill_q   <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        fill_q <= fill_d;
      end
      // Held at zero outside RUN/DRAIN, so RUN always starts from count 0.
      pace_q <= (pacing && !strobe) ? pace_q + PACE_ONE : '0;
    end
  end

  // NOTE: the entry storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_data_q    <= 2'b00;
      sym_valid_q   <= 1'b0;
      mode_active_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      sym_valid_q <= pop;
      if (pop) begin
        sym_data_q    <= head_entry.sym;
        mode_active_q <= head_entry.mode;
      end
      if (start_acc) begin
        underrun_q <= 1'b0;
      end else if (underrun_hit) begin
        underrun_q <= 1'b1;
      end
    end
  end

`ifdef BITSTREAM_SCHED_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_q <= 16'd0;
    end else if (start_acc) begin
      underrun_cnt_q <= 16'd0;
    end else if (underrun_hit && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

  assign sym_data    = sym_data_q;
  assign sym_valid   = sym_valid_q;
  assign mode_active = mode_active_q;
  assign busy        = (state_q != IDLE);
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_bitstream_sched.sv
// Self-checking bench for bitstream_sched with default parameters.
// Expected symbols come from a reference LFSR in plain integer arithmetic:
// the n-th emitted symbol is derived from the n-th LFSR step, tagged with
// the mode in force when that step was taken.
module tb_bitstream_sched;

  localparam int SPS   = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, hold, mode_req, seed_load;
  logic [31:0] seed_in;
  logic [1:0]  sym_data;
  logic        sym_valid, mode_active, busy, underrun;
`ifdef BITSTREAM_SCHED_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  bitstream_sched dut (
`ifdef BITSTREAM_SCHED_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .hold         (hold),
    .mode_req     (mode_req),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .sym_data     (sym_data),
    .sym_valid    (sym_valid),
    .mode_active  (mode_active),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned ref_s;
  int          n_emit = 0;
  int          switch_at;
  logic        mode_a, mode_b;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned ref_step(input int unsigned s);
    int unsigned fb;
    fb = ((s >> 25) ^ (s >> 15) ^ ~(s >> 5)) & 32'd1;
    return (s >> 1) | (fb << 31);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic take_sym(input string tag);
    logic       m;
    logic [1:0] es;
    m     = (n_emit >= switch_at) ? mode_b : mode_a;
    ref_s = ref_step(ref_s);
    es    = m ? 2'(ref_s & 32'd3) : 2'(ref_s & 32'd1);
    n_emit++;
    check({tag, "_sym"}, 32'(sym_data), 32'(es));
    check({tag, "_mode"}, 32'(mode_active), 32'(m));
  endtask

  task automatic wait_sym(input string tag, input int max_t, output int n);
    n = 0;
    while (n < max_t) begin
      tick();
      n++;
      if (sym_valid) break;
    end
    check({tag, "_arrive"}, 32'(sym_valid), 32'd1);
  endtask

  task automatic expect_sym(input string tag, input int max_t, output int n);
    wait_sym(tag, max_t, n);
    if (sym_valid) take_sym(tag);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sym_valid) seen++;
    end
    check({tag, "_no_valid"}, 32'(seen), 32'd0);
  endtask

  task automatic start_run(input logic m);
    mode_req  = m;
    mode_a    = m;
    mode_b    = m;
    switch_at = 32'h7fff_ffff;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Issued while RUN holds a full FIFO: exactly DEPTH symbols must follow.
  task automatic stop_drain(input string tag);
    int n;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      expect_sym($sformatf("%s_%0d", tag, i), SPS + 8, n);
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    quiet(tag, 50);
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_in   = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    int n, vc;
    logic m;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    mode_req = 1'b0; seed_load = 1'b0; seed_in = '0;
    ref_s = 32'd165;
    tick();
    tick();
    check("rst_sym_data", 32'(sym_data), 32'd0);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_mode_active", 32'(mode_active), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
`ifdef BITSTREAM_SCHED_UNDERRUN_CNT_EN
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // A: default seed, 1-bit symbols, latency and pacing
    start_run(1'b0);
    check("A_busy", 32'(busy), 32'd1);
    wait_sym("A_first", 100, n);
    check("A_latency", 32'(n + 1), 32'(DEPTH + SPS + 1));
    take_sym("A_s0");
    check("A_const0", 32'(sym_data), 32'd0);
    expect_sym("A_s1", SPS + 8, n);
    check("A_gap1", 32'(n), 32'(SPS));
    check("A_const1", 32'(sym_data), 32'd1);
    expect_sym("A_s2", SPS + 8, n);
    check("A_gap2", 32'(n), 32'(SPS));
    check("A_const2", 32'(sym_data), 32'd0);
    start = 1'b1;  // ignored while busy
    tick();
    start = 1'b0;
    check("A_busy_after_start", 32'(busy), 32'd1);
    repeat (3) tick();
    stop_drain("A_drain");

    // B: reload default seed, 2-bit symbols
    load_seed(32'h0000_00A5);
    ref_s = 32'h0000_00A5;
    start_run(1'b1);
    expect_sym("B_s0", 100, n);
    check("B_const0", 32'(sym_data), 32'd2);
    expect_sym("B_s1", SPS + 8, n);
    check("B_const1", 32'(sym_data), 32'd1);
    expect_sym("B_s2", SPS + 8, n);
    check("B_const2", 32'(sym_data), 32'd0);
    repeat (4) tick();
    stop_drain("B_drain");

    // C: mode toggle, seed_load in RUN, hold starvation
    start_run(1'b0);
    expect_sym("C_s0", 100, n);
    repeat (3) tick();
    mode_req  = 1'b1;
    mode_b    = 1'b1;
    switch_at = n_emit + DEPTH;
    load_seed($urandom);
    for (int i = 0; i < 6; i++) expect_sym($sformatf("C_m%0d", i), SPS + 8, n);
    repeat (3) tick();
    check("C_underrun_before_hold", 32'(underrun), 32'd0);
    hold = 1'b1;
    vc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sym_valid) begin
        take_sym($sformatf("C_hold%0d", vc));
        vc++;
      end
    end
    hold = 1'b0;
    check("C_hold_count", 32'(vc), 32'(DEPTH));
    check("C_underrun_set", 32'(underrun), 32'd1);
`ifdef BITSTREAM_SCHED_UNDERRUN_CNT_EN
    check("C_underrun_cnt", 32'(underrun_cnt), 32'd2);
`endif
    expect_sym("C_resume", 2 * SPS, n);
    repeat (2) tick();
    stop_drain("C_drain");
    check("C_underrun_sticky", 32'(underrun), 32'd1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("C_start_stop_busy", 32'(busy), 32'd0);
    check("C_start_stop_underrun", 32'(underrun), 32'd1);

    // D: stop during PRIME
    start_run(1'(($urandom)));
    check("D_prime_busy", 32'(busy), 32'd1);
    check("D_underrun_cleared", 32'(underrun), 32'd0);
`ifdef BITSTREAM_SCHED_UNDERRUN_CNT_EN
    check("D_underrun_cnt_cleared", 32'(underrun_cnt), 32'd0);
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("D_busy_drop", 32'(busy), 32'd0);
    quiet("D_prime", 60);

    // E: random seeds, modes and stop points
    for (int it = 0; it < 3; it++) begin
      ref_s = $urandom;
      load_seed(ref_s);
      m = 1'(($urandom_range(0, 1)));
      start_run(m);
      expect_sym($sformatf("E%0d_s0", it), 100, n);
      for (int k = 1; k < int'($urandom_range(1, 3)); k++) begin
        expect_sym($sformatf("E%0d_s%0d", it, k), SPS + 8, n);
      end
      repeat ($urandom_range(1, 20)) tick();
      stop_drain($sformatf("E%0d_drain", it));
    end

    // F: asynchronous reset in RUN
    start_run(1'b1);
    expect_sym("F_s0", 100, n);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("F_rst_sym_data", 32'(sym_data), 32'd0);
    check("F_rst_sym_valid", 32'(sym_valid), 32'd0);
    check("F_rst_mode_active", 32'(mode_active), 32'd0);
    check("F_rst_busy", 32'(busy), 32'd0);
    check("F_rst_underrun", 32'(underrun), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    quiet("F_post_reset", 80);
    check("F_post_busy", 32'(busy), 32'd0);
    ref_s = 32'd165;
    start_run(1'b0);
    expect_sym("F_reseeded", 100, n);
    repeat (4) tick();
    stop_drain("F_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitstream_sched.md
BITSTREAM_SCHED -- requirements
Module: bitstream_sched

Interface
REQ-001 The block SHALL have parameter SAMPLES_PER_SYM, default 32: number of clk cycles per output symbol (legal range 2..65535).
REQ-002 The block SHALL have parameter SEED_DEFAULT, default 32'd165: the LFSR value loaded at reset.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: number of symbol buffer entries (a power of two, 2..16).
REQ-004 Port clk, input, 1 bit: 44.1 kHz sample clock; all logic runs on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: single-cycle request to begin symbol generation.
REQ-007 Port stop, input, 1 bit: single-cycle request to end symbol generation.
REQ-008 Port hold, input, 1 bit: while high, the LFSR is frozen and no FIFO pushes occur.
REQ-009 Port mode_req, input, 1 bit: 0 selects 1-bit symbols, 1 selects 2-bit symbols.
REQ-010 Port seed_load, input, 1 bit: loads seed_in into the LFSR; honoured in IDLE only.
REQ-011 Port seed_in, input, 32 bits: seed value.
REQ-012 Port sym_data, output, 2 bits: current symbol.
REQ-013 Port sym_valid, output, 1 bit: one-cycle pulse when a new symbol appears on sym_data.
REQ-014 Port mode_active, output, 1 bit: mode tag of the symbol on sym_data.
REQ-015 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 Port underrun, output, 1 bit: sticky underrun flag.

Function
REQ-017 The FSM SHALL have the states IDLE, PRIME, RUN and DRAIN, with the following transitions:
- IDLE -> PRIME on start.
- PRIME -> RUN when the FIFO is full.
- RUN -> DRAIN on stop.
- DRAIN -> IDLE once the FIFO is empty and that cycle's strobe has completed.
REQ-018 A stop in PRIME SHALL flush the FIFO and return the FSM to IDLE.
REQ-019 A start outside IDLE SHALL be ignored.
REQ-020 When start and stop are asserted in the same cycle, stop SHALL win.
REQ-021 LFSR step:
- feedback = s[25] XOR s[15] XOR NOT s[5];
- next value = {feedback, s[31:1]}.
REQ-022 In PRIME and RUN, when the FIFO is not full and hold=0, the block SHALL step the LFSR once and push one entry that same cycle.
- The entry is {mode_req, symbol}.
- The symbol is {1'b0, s_next[0]} when mode_req=0, and s_next[1:0] when mode_req=1.
REQ-023 The pacing counter SHALL clear to 0 on entry to RUN and count 0..SAMPLES_PER_SYM-1, wrapping.
- Strobe = (count == SAMPLES_PER_SYM-1).
- The counter runs only in RUN and DRAIN.
REQ-024 On a strobe with the FIFO non-empty, the block SHALL pop the head entry into sym_data/mode_active and pulse sym_valid on the next cycle.
REQ-025 On a strobe with the FIFO empty:
- sym_valid SHALL stay 0;
- sym_data and mode_active SHALL hold their previous values;
- in RUN only, underrun SHALL be set.
REQ-026 A push and a pop in the same cycle SHALL both take effect, leaving the FIFO occupancy unchanged.
REQ-027 A change on mode_req SHALL affect only entries pushed afterwards; buffered symbols keep their original tag.
REQ-028 The first sym_valid after start SHALL occur exactly FIFO_DEPTH + SAMPLES_PER_SYM + 1 cycles after the start cycle (with hold=0).
REQ-029 underrun SHALL clear only on reset or on an accepted start.
REQ-030 seed_load while not in IDLE SHALL be ignored.

Reset
REQ-031 On rst_n low, the block SHALL immediately force:
- state to IDLE;
- LFSR to SEED_DEFAULT;
- FIFO to empty (read and write pointers 0);
- pacing counter to 0.
REQ-032 On rst_n low, the outputs SHALL immediately be: sym_data=2'b00, sym_valid=0, mode_active=0, busy=0, underrun=0.
REQ-033 Reset asserted mid-RUN SHALL discard all buffered symbols with no further sym_valid pulse.

Configuration
REQ-034 With macro BITSTREAM_SCHED_UNDERRUN_CNT_EN defined, the block SHALL add output port underrun_cnt, 16 bits.
- It counts strobes where REQ-025 sets underrun, saturating at 16'hFFFF.
- It resets to 0, and clears on an accepted start.
REQ-035 Without BITSTREAM_SCHED_UNDERRUN_CNT_EN defined, the port and the counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-036 The shared package bitstream_pkg SHALL contain:
- the FSM state enum (sched_state_t);
- the FIFO entry typedef (mode bit plus 2-bit symbol);
- the LFSR tap positions 25, 15 and 5;
- the default seed 165.
REQ-037 The LFSR SHALL be a separate sub-module, lfsr32_step, with ports clk, rst_n, step, load, load_val and state.
- Step precedence: load beats step.
- The FIFO and the FSM stay in bitstream_sched.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Defaults, mode_req=0, start: sym_data sequence 2'b00, 2'b01, 2'b00, first sym_valid 37 cycles after start, then one pulse every 32 cycles.
- Defaults, mode_req=1: sym_data sequence 2'b10, 2'b01, 2'b00, each with mode_active=1.
- In RUN, toggle mode_req 0->1: the next 4 symbols keep mode_active=0, then switch to 1.
- hold high for 200 cycles in RUN: 4 symbols drain, then underrun=1 with no sym_valid; with the macro enabled, underrun_cnt increments once per strobe.
- stop in RUN: exactly the buffered symbols emerge, then busy=0. stop in PRIME: busy drops the next cycle with no sym_valid.
- seed_load with 32'h0000_00A5 in IDLE reproduces the default sequence; seed_load in RUN leaves the sequence unaffected; rst_n low mid-RUN zeroes all outputs asynchronously.
